// File: rtl/seq_addsub_chunked.sv
// rtl/seq_addsub_chunked.sv - multi-cycle chunked add/subtract unit with start/done handshake
//
// Adds or subtracts two WIDTH-bit operands one CHUNK-bit slice per cycle,
// LSB slice first, carrying between slices through a register.
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      request; accepted only while busy=0
//   sub       in   1      0: a+b+cin, 1: a-b-cin
//   a, b      in   WIDTH  operands, sampled on an accepted start
//   cin       in   1      carry-in (add) / borrow-in (sub), sampled on an accepted start
//   busy      out  1      high while slices are being processed
//   done      out  1      one-cycle pulse when sum/cout/overflow are updated
//   sum       out  WIDTH  registered result, held until the next done
//   cout      out  1      unsigned carry-out; for sub, 1 means no borrow
//   overflow  out  1      two's-complement signed overflow
module seq_addsub_chunked #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
            $error("seq_addsub_chunked: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;   // already inverted for subtraction
    logic [WIDTH-1:0] r;
    logic             c;
    logic [CW-1:0]    cnt;

    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK-1:0] s_sl;
    logic             c_next;
    logic             c_msb;
    logic [WIDTH-1:0] r_next;
    logic             last;

    always_comb begin
        a_sl             = a_reg[cnt*CHUNK +: CHUNK];
        b_sl             = b_reg[cnt*CHUNK +: CHUNK];
        {c_next, s_sl}   = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, c};
        // Carry into a bit position is recovered from a ^ b ^ sum at that bit;
        // this also covers CHUNK=1, where the slice MSB is the only bit.
        c_msb            = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ s_sl[CHUNK-1];
        r_next           = r;
        r_next[cnt*CHUNK +: CHUNK] = s_sl;
        last             = (cnt == CW'(NCHUNK - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            r        <= '0;
            c        <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + ~cin, so the borrow-in inverts too.
                        a_reg <= a;
                        b_reg <= sub ? ~b : b;
                        c     <= sub ? ~cin : cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r <= r_next;
                    c <= c_next;
                    if (last) begin
                        sum      <= r_next;
                        cout     <= c_next;
                        overflow <= c_msb ^ c_next;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
